// File: rtl/freq_meter_if.sv
// Control/result bundle of the reciprocal frequency meter.
// The master drives start/cont/si, and the slave (the meter) returns status and BCD result.
interface freq_meter_if #(
  parameter int unsigned DIGITS = 5
) ();
  logic                start;
  logic                cont;
  logic                si;
  logic                ready;
  logic                done_tick;
  logic                ovf;
  logic                tout;
  logic [4*DIGITS-1:0] bcd;

  modport master (
    output start, cont, si,
    input  ready, done_tick, ovf, tout, bcd
  );

  modport slave (
    input  start, cont, si,
    output ready, done_tick, ovf, tout, bcd
  );
endinterface

// File: rtl/freq_meter.sv
// Reciprocal frequency meter: counts ticks over 2**NAVG_LOG2 periods of si, divides
// (TICK_HZ<<NAVG_LOG2) by the count, and converts the quotient to packed BCD.
module freq_meter #(
  parameter int unsigned TICK_DIV  = 50,
  parameter int unsigned TICK_HZ   = 1_000_000,
  parameter int unsigned NAVG_LOG2 = 0,
  parameter int unsigned CW        = 24,
  parameter int unsigned DIGITS    = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  freq_meter_if.slave bus
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned BW = 4 * DIGITS;
  localparam logic [63:0] DividendWide = 64'(TICK_HZ) << NAVG_LOG2;
  localparam logic [31:0] Dividend = DividendWide[31:0];
  localparam logic [31:0] Limit = 32'(10 ** DIGITS);
  localparam logic [3:0]  NAvg = 4'(1 << NAVG_LOG2);
  localparam logic [CW-1:0] TickMax = '1;

  typedef enum logic [2:0] {StIdle, StWait, StMeas, StDiv, StB2b, StDone} state_e;

  state_e          state_q, state_d;
  logic [2:0]      sync_q, sync_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [CW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [3:0]      edge_cnt_q, edge_cnt_d;
  logic [31:0]     divisor_q, divisor_d;
  logic [31:0]     rem_q, rem_d;
  logic [31:0]     quo_q, quo_d;
  logic [BW-1:0]   acc_q, acc_d;
  logic [5:0]      step_q, step_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            ovf_q, ovf_d;
  logic            tout_q, tout_d;

  logic            tick;
  logic            si_rise;
  logic [CW-1:0]   ticks_now;
  logic [32:0]     rem_sh;
  logic [BW-1:0]   acc_adj;

  assign tick    = (presc_q == PW'(TICK_DIV - 1));
  assign si_rise = sync_q[1] & ~sync_q[2];

  always_comb begin
    state_d    = state_q;
    sync_d     = {sync_q[1:0], bus.si};
    presc_d    = tick ? '0 : presc_q + PW'(1);
    tick_cnt_d = tick_cnt_q;
    edge_cnt_d = edge_cnt_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    acc_d      = acc_q;
    step_d     = step_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    tout_d     = tout_q;
    ticks_now  = (tick && (tick_cnt_q != TickMax)) ? tick_cnt_q + CW'(1) : tick_cnt_q;
    rem_sh     = {rem_q, quo_q[31]};
    acc_adj    = acc_q;

    unique case (state_q)
      StIdle: begin
        presc_d    = '0;
        tick_cnt_d = '0;
        if (bus.start) state_d = StWait;
      end
      StWait: begin
        if (si_rise) begin
          state_d    = StMeas;
          tick_cnt_d = '0;
          edge_cnt_d = '0;
        end else if (tick_cnt_q == TickMax) begin
          state_d = StDone;
          bcd_d   = '0;
          ovf_d   = 1'b0;
          tout_d  = 1'b1;
        end else begin
          tick_cnt_d = ticks_now;
        end
      end
      StMeas: begin
        // A tick coinciding with the closing edge still belongs to this measurement.
        if (si_rise && (edge_cnt_q + 4'd1 == NAvg)) begin
          state_d   = StDiv;
          divisor_d = 32'(ticks_now);
          step_d    = '0;
        end else if (tick_cnt_q == TickMax) begin
          state_d = StDone;
          bcd_d   = '0;
          ovf_d   = 1'b0;
          tout_d  = 1'b1;
        end else begin
          tick_cnt_d = ticks_now;
          if (si_rise) edge_cnt_d = edge_cnt_q + 4'd1;
        end
      end
      StDiv: begin
        if (step_q == 6'd0) begin
          if (divisor_q == '0) begin
            state_d = StDone;
            bcd_d   = {DIGITS{4'h9}};
            ovf_d   = 1'b1;
            tout_d  = 1'b0;
          end else begin
            rem_d  = '0;
            quo_d  = Dividend;
            step_d = 6'd1;
          end
        end else begin
          // Restoring step: shift remainder:quotient left, subtract divisor when it fits.
          quo_d = {quo_q[30:0], 1'b0};
          if (rem_sh >= {1'b0, divisor_q}) begin
            rem_d    = rem_sh[31:0] - divisor_q;
            quo_d[0] = 1'b1;
          end else begin
            rem_d = rem_sh[31:0];
          end
          if (step_q == 6'd32) begin
            state_d = StB2b;
            step_d  = '0;
            acc_d   = '0;
          end else begin
            step_d = step_q + 6'd1;
          end
        end
      end
      StB2b: begin
        if ((step_q == 6'd0) && (quo_q >= Limit)) begin
          state_d = StDone;
          bcd_d   = {DIGITS{4'h9}};
          ovf_d   = 1'b1;
          tout_d  = 1'b0;
        end else begin
          for (int i = 0; i < int'(DIGITS); i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
          end
          acc_d = {acc_adj[BW-2:0], quo_q[31]};
          quo_d = {quo_q[30:0], 1'b0};
          if (step_q == 6'd31) begin
            state_d = StDone;
            bcd_d   = acc_d;
            ovf_d   = 1'b0;
            tout_d  = 1'b0;
          end else begin
            step_d = step_q + 6'd1;
          end
        end
      end
      StDone: begin
        tick_cnt_d = '0;
        state_d    = bus.cont ? StWait : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      sync_q     <= '0;
      presc_q    <= '0;
      tick_cnt_q <= '0;
      edge_cnt_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      acc_q      <= '0;
      step_q     <= '0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      tout_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      presc_q    <= presc_d;
      tick_cnt_q <= tick_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      acc_q      <= acc_d;
      step_q     <= step_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      tout_q     <= tout_d;
    end
  end

  assign bus.ready     = (state_q == StIdle);
  assign bus.done_tick = (state_q == StDone);
  assign bus.ovf       = ovf_q;
  assign bus.tout      = tout_q;
  assign bus.bcd       = bcd_q;

  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (DividendWide < 64'h1_0000_0000)
        else $error("freq_meter: TICK_HZ<<NAVG_LOG2 does not fit in 32 bits");
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: four parameterisations share one si source and reset,
// each started individually; results are compared against hand-computed values.
module tb_freq_meter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cont;
  logic       si;
  logic [3:0] start_v;
  logic [3:0] done_v;
  logic       si_en;
  int         si_period;
  int         n_checks = 0;
  int         n_pass = 0;
  int         n_done [4];
  int         base;

  always #5 clk = ~clk;

  freq_meter_if #(.DIGITS(5)) if_a ();
  freq_meter_if #(.DIGITS(5)) if_b ();
  freq_meter_if #(.DIGITS(4)) if_c ();
  freq_meter_if #(.DIGITS(5)) if_d ();

  freq_meter #(.TICK_DIV(5), .TICK_HZ(1_000_000), .NAVG_LOG2(0), .CW(24), .DIGITS(5)) u_a (
    .clk(clk), .reset_n(reset_n), .bus(if_a));
  freq_meter #(.TICK_DIV(5), .TICK_HZ(1_000_000), .NAVG_LOG2(2), .CW(24), .DIGITS(5)) u_b (
    .clk(clk), .reset_n(reset_n), .bus(if_b));
  freq_meter #(.TICK_DIV(5), .TICK_HZ(1_000_000), .NAVG_LOG2(0), .CW(24), .DIGITS(4)) u_c (
    .clk(clk), .reset_n(reset_n), .bus(if_c));
  freq_meter #(.TICK_DIV(5), .TICK_HZ(1_000_000), .NAVG_LOG2(0), .CW(10), .DIGITS(5)) u_d (
    .clk(clk), .reset_n(reset_n), .bus(if_d));

  assign if_a.si = si;
  assign if_b.si = si;
  assign if_c.si = si;
  assign if_d.si = si;
  assign if_a.cont = cont;
  assign if_b.cont = cont;
  assign if_c.cont = cont;
  assign if_d.cont = cont;
  assign if_a.start = start_v[0];
  assign if_b.start = start_v[1];
  assign if_c.start = start_v[2];
  assign if_d.start = start_v[3];
  assign done_v = {if_d.done_tick, if_c.done_tick, if_b.done_tick, if_a.done_tick};

  initial for (int i = 0; i < 4; i++) n_done[i] = 0;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) if (done_v[i] === 1'b1) n_done[i]++;
  end

  // Square-wave source: period in clk cycles, re-read at each half so changes apply promptly.
  initial begin
    si = 1'b0;
    forever begin
      @(negedge clk);
      if (si_en) begin
        si = 1'b1;
        repeat (si_period / 2) @(negedge clk);
        si = 1'b0;
        repeat (si_period - si_period / 2 - 1) @(negedge clk);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic pulse_start(input int idx);
    @(negedge clk);
    start_v[idx] = 1'b1;
    @(negedge clk);
    start_v[idx] = 1'b0;
  endtask

  task automatic wait_done(input int idx, input int target, input int budget, input string tag);
    int k = 0;
    while ((n_done[idx] < target) && (k < budget)) begin
      @(negedge clk);
      k++;
    end
    check(tag, 64'(n_done[idx] >= target), 64'd1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    reset_n   = 1'b0;
    cont      = 1'b0;
    start_v   = '0;
    si_en     = 1'b0;
    si_period = 2500;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 64'(if_a.ready), 64'd1);
    check("rst_done", 64'(if_a.done_tick), 64'd0);
    check("rst_ovf", 64'(if_a.ovf), 64'd0);
    check("rst_tout", 64'(if_a.tout), 64'd0);
    check("rst_bcd", 64'(if_a.bcd), 64'd0);

    // 1: 500-tick period -> 2000 Hz; second start while busy must be ignored
    si_en = 1'b1;
    repeat (10) @(negedge clk);
    pulse_start(0);
    repeat (300) @(negedge clk);
    pulse_start(0);
    wait_done(0, 1, 8000, "t1_done");
    check("t1_bcd", 64'(if_a.bcd), 64'h02000);
    check("t1_ovf", 64'(if_a.ovf), 64'd0);
    check("t1_tout", 64'(if_a.tout), 64'd0);
    repeat (3000) @(negedge clk);
    check("t1_single", 64'(n_done[0]), 64'd1);
    check("t1_ready", 64'(if_a.ready), 64'd1);

    // 2: four periods of 300 ticks averaged -> 4e6/1200
    si_period = 1500;
    repeat (3000) @(negedge clk);
    pulse_start(1);
    wait_done(1, 1, 12000, "t2_done");
    check("t2_bcd", 64'(if_b.bcd), 64'h03333);
    check("t2_tout", 64'(if_b.tout), 64'd0);
    check("t2_ovf", 64'(if_b.ovf), 64'd0);

    // 3: 20000 Hz does not fit four digits
    si_period = 250;
    repeat (2000) @(negedge clk);
    pulse_start(2);
    wait_done(2, 1, 3000, "t3_done");
    check("t3_ovf", 64'(if_c.ovf), 64'd1);
    check("t3_bcd", 64'(if_c.bcd), 64'h9999);
    check("t3_tout", 64'(if_c.tout), 64'd0);
    repeat (1000) @(negedge clk);
    check("t3_single", 64'(n_done[2]), 64'd1);

    // 4: no edges, CW=10 -> timeout after 1023 ticks (~5115 clk)
    si_en = 1'b0;
    repeat (500) @(negedge clk);
    pulse_start(3);
    repeat (5000) @(negedge clk);
    check("t4_early", 64'(n_done[3]), 64'd0);
    wait_done(3, 1, 400, "t4_done");
    check("t4_tout", 64'(if_d.tout), 64'd1);
    check("t4_bcd", 64'(if_d.bcd), 64'd0);
    check("t4_ovf", 64'(if_d.ovf), 64'd0);
    repeat (2) @(negedge clk);
    check("t4_ready", 64'(if_d.ready), 64'd1);

    // 5: continuous mode, period change, then cont dropped mid-measurement
    cont      = 1'b1;
    si_period = 2500;
    si_en     = 1'b1;
    repeat (100) @(negedge clk);
    pulse_start(0);
    wait_done(0, 2, 8000, "t5_done1");
    check("t5_bcd1", 64'(if_a.bcd), 64'h02000);
    si_period = 1250;
    wait_done(0, 3, 8000, "t5_done2");
    check("t5_bcd2", 64'(if_a.bcd), 64'h04000);
    repeat (200) @(negedge clk);
    cont = 1'b0;
    wait_done(0, 4, 8000, "t5_done3");
    check("t5_bcd3", 64'(if_a.bcd), 64'h04000);
    repeat (10) @(negedge clk);
    check("t5_idle", 64'(if_a.ready), 64'd1);
    repeat (3000) @(negedge clk);
    check("t5_stopped", 64'(n_done[0]), 64'd4);

    // 6a: reset while measuring
    si_en = 1'b0;
    repeat (2000) @(negedge clk);
    pulse_start(0);
    repeat (5) @(negedge clk);
    si = 1'b1;
    repeat (10) @(negedge clk);
    si = 1'b0;
    repeat (100) @(negedge clk);
    pulse_start(0);
    base = n_done[0];
    pulse_reset();
    check("t6_ready", 64'(if_a.ready), 64'd1);
    check("t6_bcd", 64'(if_a.bcd), 64'd0);
    check("t6_done", 64'(if_a.done_tick), 64'd0);
    check("t6_c_bcd", 64'(if_c.bcd), 64'd0);
    check("t6_c_ovf", 64'(if_c.ovf), 64'd0);
    check("t6_d_tout", 64'(if_d.tout), 64'd0);
    repeat (3000) @(negedge clk);
    check("t6_no_done", 64'(n_done[0]), 64'(base));

    // 6b: reset while dividing (10-tick period)
    pulse_start(0);
    repeat (5) @(negedge clk);
    si = 1'b1;
    repeat (10) @(negedge clk);
    si = 1'b0;
    repeat (40) @(negedge clk);
    si = 1'b1;
    repeat (15) @(negedge clk);
    pulse_reset();
    si = 1'b0;
    check("t6b_ready", 64'(if_a.ready), 64'd1);
    check("t6b_bcd", 64'(if_a.bcd), 64'd0);
    check("t6b_ovf", 64'(if_a.ovf), 64'd0);
    repeat (200) @(negedge clk);
    check("t6b_no_done", 64'(n_done[0]), 64'(base));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
